// File: rtl/bus_slave_arbiter_ws_if.sv
// bus_slave_arbiter_ws_if: core-master request/response bus plus per-slave select/data/ready lines
interface bus_slave_arbiter_ws_if #(parameter int SLAVE_COUNT = 7);
  logic m_req, m_gnt, m_we, m_rvalid, m_err, s_we;
  logic [31:0] m_addr, m_wdata, m_rdata, s_addr, s_wdata;
  logic [3:0] m_be, s_be;
  logic [SLAVE_COUNT-1:0] s_sel, s_ready;
  logic [SLAVE_COUNT*32-1:0] s_rdata;
  modport slave (
    input  m_req, m_addr, m_we, m_be, m_wdata, s_rdata, s_ready,
    output m_gnt, m_rvalid, m_rdata, m_err, s_sel, s_addr, s_we, s_be, s_wdata
  );
  modport master (
    output m_req, m_addr, m_we, m_be, m_wdata, s_rdata, s_ready,
    input  m_gnt, m_rvalid, m_rdata, m_err, s_sel, s_addr, s_we, s_be, s_wdata
  );
endinterface

// File: rtl/bus_slave_arbiter_ws.sv
// bus_slave_arbiter_ws: address decoder and wait-state controller between one master and N slaves
module bus_slave_arbiter_ws #(
  parameter int                          SLAVE_COUNT     = 7,
  parameter logic [SLAVE_COUNT*32-1:0]   SLAVE_START     = {SLAVE_COUNT{32'h0}},
  parameter logic [SLAVE_COUNT*32-1:0]   SLAVE_END       = {SLAVE_COUNT{32'h0}},
  parameter logic [SLAVE_COUNT*8-1:0]    SLAVE_LATENCY   = {SLAVE_COUNT{8'd0}},
  parameter logic [SLAVE_COUNT-1:0]      SLAVE_HANDSHAKE = '0,
  parameter logic [SLAVE_COUNT-1:0]      SLAVE_RO        = '0,
  parameter int                          TIMEOUT_CYCLES  = 255
) (
  input logic clk,
  input logic rst,
  bus_slave_arbiter_ws_if.slave bus
);
  localparam int IW = SLAVE_COUNT > 1 ? $clog2(SLAVE_COUNT) : 1;
  typedef enum logic [2:0] {IDLE, SELECT, WAIT, RESP, RESP_ERR} state_t;
  state_t state;
  logic [IW-1:0] idx, hit_idx;
  logic hit;
  logic [15:0] cnt;
  logic [7:0] lat;
  logic [31:0] rd;
  // descending scan so the lowest matching index is the last one assigned
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int i = SLAVE_COUNT - 1; i >= 0; i--)
      if (bus.m_addr >= SLAVE_START[i*32 +: 32] && bus.m_addr <= SLAVE_END[i*32 +: 32]) begin
        hit = 1'b1;
        hit_idx = IW'(i);
      end
  end
  assign lat = SLAVE_LATENCY[int'(idx)*8 +: 8];
  assign rd = bus.s_rdata[int'(idx)*32 +: 32];
  assign bus.m_gnt = bus.m_req && state == IDLE && !rst;
  // fixed slaves load latency-1 so a zero-latency slave answers straight from SELECT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      bus.s_sel <= '0;
      bus.s_addr <= '0;
      bus.s_we <= 1'b0;
      bus.s_be <= '0;
      bus.s_wdata <= '0;
      bus.m_rvalid <= 1'b0;
      bus.m_rdata <= '0;
      bus.m_err <= 1'b0;
    end else begin
      bus.s_sel <= '0;
      bus.m_rvalid <= 1'b0;
      bus.m_err <= 1'b0;
      case (state)
        IDLE: if (bus.m_req) begin
          idx <= hit_idx;
          bus.s_addr <= bus.m_addr;
          bus.s_we <= bus.m_we;
          bus.s_be <= bus.m_be;
          bus.s_wdata <= bus.m_wdata;
          if (!hit || (bus.m_we && SLAVE_RO[hit_idx])) begin
            state <= RESP_ERR;
            bus.m_rvalid <= 1'b1;
            bus.m_err <= 1'b1;
            bus.m_rdata <= '0;
          end else begin
            state <= SELECT;
            bus.s_sel <= SLAVE_COUNT'(1) << hit_idx;
          end
        end
        SELECT: if (SLAVE_HANDSHAKE[idx]) begin
          cnt <= 16'(TIMEOUT_CYCLES);
          state <= WAIT;
        end else if (lat == 8'd0) begin
          state <= RESP;
          bus.m_rvalid <= 1'b1;
          bus.m_rdata <= rd;
        end else begin
          cnt <= {8'd0, lat} - 16'd1;
          state <= WAIT;
        end
        WAIT: if (SLAVE_HANDSHAKE[idx] ? bus.s_ready[idx] : cnt == 16'd0) begin
          state <= RESP;
          bus.m_rvalid <= 1'b1;
          bus.m_rdata <= rd;
        end else if (SLAVE_HANDSHAKE[idx] && cnt == 16'd0) begin
          state <= RESP_ERR;
          bus.m_rvalid <= 1'b1;
          bus.m_err <= 1'b1;
          bus.m_rdata <= '0;
        end else begin
          cnt <= cnt - 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_slave_arbiter_ws.sv
// tb_bus_slave_arbiter_ws: directed tests of decode, wait states, protection, handshake and reset
module tb_bus_slave_arbiter_ws;
  localparam int N = 7;
  localparam logic [N*32-1:0] START = {32'h2000_0000, 32'h1F00_0000, 32'h1D00_0000, 32'h1C00_0000,
                                       32'h1B00_1000, 32'h1B00_0000, 32'h1A00_0000};
  localparam logic [N*32-1:0] STOP  = {32'h2000_FFFF, 32'h1F00_0FFF, 32'h1D00_0FFF, 32'h1C00_0FFF,
                                       32'h1B00_2FFF, 32'h1B00_1FFF, 32'h1A00_1FFF};
  localparam logic [N*8-1:0] LAT = {8'd255, 8'd0, 8'd7, 8'd0, 8'd0, 8'd2, 8'd1};
  logic clk, rst;
  int pass = 0, total = 0;
  bus_slave_arbiter_ws_if #(.SLAVE_COUNT(N)) bus();
  bus_slave_arbiter_ws #(
    .SLAVE_COUNT(N), .SLAVE_START(START), .SLAVE_END(STOP), .SLAVE_LATENCY(LAT),
    .SLAVE_HANDSHAKE(7'b0001000), .SLAVE_RO(7'b0000001), .TIMEOUT_CYCLES(4)
  ) dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  task automatic xact(input logic [31:0] a, input logic we, input logic [31:0] wd, input int rdy_at,
                      output logic g, output int lat, output logic [N-1:0] sel_or, output int sel_at,
                      output int sel_n, output logic [31:0] rd, output logic e);
    @(negedge clk);
    bus.m_req = 1'b1; bus.m_addr = a; bus.m_we = we; bus.m_be = 4'hA; bus.m_wdata = wd; bus.s_ready = '0;
    #1 g = bus.m_gnt;
    @(posedge clk);
    #1;
    bus.m_req = 1'b0; bus.m_addr = 32'h1E00_0000; bus.m_wdata = ~wd; bus.m_we = ~we; bus.m_be = 4'h5;
    lat = -1; sel_or = '0; sel_at = -1; sel_n = 0; rd = 'x; e = 1'bx;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      bus.s_ready = (c >= rdy_at) ? '1 : '0;
      if (bus.s_sel != '0) begin
        if (sel_at < 0) sel_at = c;
        sel_n++;
      end
      sel_or |= bus.s_sel;
      if (bus.m_rvalid) begin
        lat = c; rd = bus.m_rdata; e = bus.m_err;
        break;
      end
    end
    bus.s_ready = '0;
  endtask
  task automatic test_reset;
    bus.m_req = 1'b1; bus.m_addr = 32'h1A00_0000; bus.m_we = 1'b0; bus.m_be = 4'hF; bus.m_wdata = 32'h1234_5678;
    bus.s_ready = '0;
    bus.s_rdata = {32'h6666_6666, 32'h5555_5555, 32'h4444_4444, 32'h3333_3333,
                   32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};
    rst = 1'b0;
    #3 rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (bus.m_gnt !== 1'b0) $display("FAIL reset_gnt got %b exp 0", bus.m_gnt); else pass++;
    total++; if (bus.m_rvalid !== 1'b0 || bus.m_err !== 1'b0 || bus.m_rdata !== 32'h0)
      $display("FAIL reset_resp got rvalid=%b err=%b rdata=%h exp 0/0/0", bus.m_rvalid, bus.m_err, bus.m_rdata); else pass++;
    total++; if (bus.s_sel !== '0 || bus.s_addr !== 32'h0 || bus.s_we !== 1'b0 || bus.s_be !== 4'h0 || bus.s_wdata !== 32'h0)
      $display("FAIL reset_slave got sel=%h addr=%h we=%b be=%h wdata=%h exp all 0",
               bus.s_sel, bus.s_addr, bus.s_we, bus.s_be, bus.s_wdata); else pass++;
    rst = 1'b0; bus.m_req = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_fixed_read;
    logic g, e; int lat, sa, sn; logic [N-1:0] so; logic [31:0] rd;
    xact(32'h1A00_0000, 1'b0, 32'h0, 1000, g, lat, so, sa, sn, rd, e);
    total++; if (g !== 1'b1) $display("FAIL fixed_gnt got %b exp 1", g); else pass++;
    total++; if (sa !== 1 || sn !== 1 || so !== 7'h01) $display("FAIL fixed_sel got at=%0d n=%0d sel=%h exp 1/1/01", sa, sn, so); else pass++;
    total++; if (lat !== 3 || rd !== 32'hDEAD_BEEF || e !== 1'b0)
      $display("FAIL fixed_resp got cyc=%0d rdata=%h err=%b exp 3/deadbeef/0", lat, rd, e); else pass++;
    total++; if (bus.s_addr !== 32'h1A00_0000 || bus.s_we !== 1'b0) $display("FAIL fixed_latch got addr=%h we=%b exp 1a000000/0", bus.s_addr, bus.s_we); else pass++;
  endtask
  task automatic test_boundary;
    logic g, e; int lat, sa, sn; logic [N-1:0] so; logic [31:0] rd;
    xact(32'h1A00_1FFF, 1'b0, 32'h0, 1000, g, lat, so, sa, sn, rd, e);
    total++; if (lat !== 3 || so !== 7'h01 || e !== 1'b0) $display("FAIL bound_end got cyc=%0d sel=%h err=%b exp 3/01/0", lat, so, e); else pass++;
    xact(32'h1A00_2000, 1'b0, 32'h0, 1000, g, lat, so, sa, sn, rd, e);
    total++; if (lat !== 1 || so !== 7'h00 || e !== 1'b1) $display("FAIL bound_past got cyc=%0d sel=%h err=%b exp 1/00/1", lat, so, e); else pass++;
    xact(32'h19FF_FFFF, 1'b0, 32'h0, 1000, g, lat, so, sa, sn, rd, e);
    total++; if (lat !== 1 || so !== 7'h00 || e !== 1'b1) $display("FAIL bound_below got cyc=%0d sel=%h err=%b exp 1/00/1", lat, so, e); else pass++;
    xact(32'h2000_0040, 1'b0, 32'h0, 1000, g, lat, so, sa, sn, rd, e);
    total++; if (lat !== 257 || rd !== 32'h6666_6666 || e !== 1'b0)
      $display("FAIL lat255 got cyc=%0d rdata=%h err=%b exp 257/66666666/0", lat, rd, e); else pass++;
  endtask
  task automatic test_unmapped;
    logic g, e; int lat, sa, sn; logic [N-1:0] so; logic [31:0] rd;
    xact(32'h1E00_0000, 1'b0, 32'h0, 1000, g, lat, so, sa, sn, rd, e);
    total++; if (g !== 1'b1 || lat !== 1) $display("FAIL unmapped_timing got gnt=%b cyc=%0d exp 1/1", g, lat); else pass++;
    total++; if (e !== 1'b1 || rd !== 32'h0 || so !== 7'h00)
      $display("FAIL unmapped_resp got err=%b rdata=%h sel=%h exp 1/0/00", e, rd, so); else pass++;
  endtask
  task automatic test_read_only;
    logic g, e; int lat, sa, sn; logic [N-1:0] so; logic [31:0] rd;
    xact(32'h1A00_0010, 1'b1, 32'hAAAA_5555, 1000, g, lat, so, sa, sn, rd, e);
    total++; if (lat !== 1 || e !== 1'b1 || so !== 7'h00) $display("FAIL ro_write got cyc=%0d err=%b sel=%h exp 1/1/00", lat, e, so); else pass++;
    xact(32'h1A00_0010, 1'b0, 32'h0, 1000, g, lat, so, sa, sn, rd, e);
    total++; if (lat !== 3 || e !== 1'b0 || rd !== 32'hDEAD_BEEF) $display("FAIL ro_read got cyc=%0d err=%b rdata=%h exp 3/0/deadbeef", lat, e, rd); else pass++;
    xact(32'h1B00_0004, 1'b1, 32'hCAFE_F00D, 1000, g, lat, so, sa, sn, rd, e);
    total++; if (lat !== 4 || e !== 1'b0 || so !== 7'h02) $display("FAIL rw_write got cyc=%0d err=%b sel=%h exp 4/0/02", lat, e, so); else pass++;
    total++; if (bus.s_addr !== 32'h1B00_0004 || bus.s_we !== 1'b1 || bus.s_be !== 4'hA || bus.s_wdata !== 32'hCAFE_F00D)
      $display("FAIL rw_latch got addr=%h we=%b be=%h wdata=%h exp 1b000004/1/a/cafef00d",
               bus.s_addr, bus.s_we, bus.s_be, bus.s_wdata); else pass++;
  endtask
  task automatic test_handshake;
    logic g, e; int lat, sa, sn; logic [N-1:0] so; logic [31:0] rd;
    xact(32'h1C00_0000, 1'b0, 32'h0, 5, g, lat, so, sa, sn, rd, e);
    total++; if (lat !== 6 || rd !== 32'h3333_3333 || e !== 1'b0 || so !== 7'h08)
      $display("FAIL hs_ready got cyc=%0d rdata=%h err=%b sel=%h exp 6/33333333/0/08", lat, rd, e, so); else pass++;
    xact(32'h1C00_0000, 1'b0, 32'h0, 1000, g, lat, so, sa, sn, rd, e);
    total++; if (lat !== 7 || rd !== 32'h0 || e !== 1'b1) $display("FAIL hs_timeout got cyc=%0d rdata=%h err=%b exp 7/0/1", lat, rd, e); else pass++;
    xact(32'h1C00_0000, 1'b0, 32'h0, 1, g, lat, so, sa, sn, rd, e);
    total++; if (lat !== 3 || e !== 1'b0) $display("FAIL hs_early got cyc=%0d err=%b exp 3/0", lat, e); else pass++;
  endtask
  task automatic test_overlap_busy;
    logic g, e; int lat, sa, sn, bad, got; logic [N-1:0] so; logic [31:0] rd;
    xact(32'h1B00_1000, 1'b0, 32'h0, 1000, g, lat, so, sa, sn, rd, e);
    total++; if (so !== 7'h02 || lat !== 4 || rd !== 32'h1111_1111)
      $display("FAIL overlap got sel=%h cyc=%0d rdata=%h exp 02/4/11111111", so, lat, rd); else pass++;
    @(negedge clk);
    bus.m_req = 1'b1; bus.m_addr = 32'h1B00_1000; bus.m_we = 1'b0;
    #1 total++; if (bus.m_gnt !== 1'b1) $display("FAIL busy_first_gnt got %b exp 1", bus.m_gnt); else pass++;
    bad = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (bus.m_gnt !== 1'b0) bad++;
    end
    total++; if (bad !== 0 || bus.m_rvalid !== 1'b1) $display("FAIL busy_hold got gnt_cycles=%0d rvalid=%b exp 0/1", bad, bus.m_rvalid); else pass++;
    @(negedge clk);
    total++; if (bus.m_gnt !== 1'b1) $display("FAIL busy_regrant got %b exp 1", bus.m_gnt); else pass++;
    @(posedge clk);
    #1 bus.m_req = 1'b0;
    got = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.m_rvalid) begin got = c; break; end
    end
    total++; if (got !== 4) $display("FAIL busy_second got cyc=%0d exp 4", got); else pass++;
  endtask
  task automatic test_back_to_back;
    logic g, e; int lat, sa, sn; logic [N-1:0] so; logic [31:0] rd;
    xact(32'h1B00_2000, 1'b0, 32'h0, 1000, g, lat, so, sa, sn, rd, e);
    total++; if (lat !== 2 || so !== 7'h04 || rd !== 32'h2222_2222) $display("FAIL lat0_s2 got cyc=%0d sel=%h rdata=%h exp 2/04/22222222", lat, so, rd); else pass++;
    xact(32'h1F00_0000, 1'b0, 32'h0, 1000, g, lat, so, sa, sn, rd, e);
    total++; if (g !== 1'b1 || lat !== 2 || rd !== 32'h5555_5555) $display("FAIL b2b_first got gnt=%b cyc=%0d rdata=%h exp 1/2/55555555", g, lat, rd); else pass++;
    xact(32'h1F00_0004, 1'b0, 32'h0, 1000, g, lat, so, sa, sn, rd, e);
    total++; if (g !== 1'b1 || lat !== 2 || rd !== 32'h5555_5555) $display("FAIL b2b_second got gnt=%b cyc=%0d rdata=%h exp 1/2/55555555", g, lat, rd); else pass++;
  endtask
  task automatic test_reset_mid;
    logic g, e; int lat, sa, sn, seen; logic [N-1:0] so; logic [31:0] rd;
    @(negedge clk);
    bus.m_req = 1'b1; bus.m_addr = 32'h1D00_0000; bus.m_we = 1'b0;
    @(posedge clk);
    #1 bus.m_req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1; bus.m_req = 1'b1;
    #1;
    total++; if (bus.m_gnt !== 1'b0 || bus.s_sel !== '0 || bus.m_rvalid !== 1'b0 || bus.m_rdata !== 32'h0 || bus.s_addr !== 32'h0)
      $display("FAIL midrst_outputs got gnt=%b sel=%h rvalid=%b rdata=%h addr=%h exp all 0",
               bus.m_gnt, bus.s_sel, bus.m_rvalid, bus.m_rdata, bus.s_addr); else pass++;
    @(negedge clk);
    rst = 1'b0; bus.m_req = 1'b0;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.m_rvalid) seen++;
    end
    total++; if (seen !== 0) $display("FAIL midrst_stale got rvalid_cycles=%0d exp 0", seen); else pass++;
    xact(32'h1F00_0000, 1'b0, 32'h0, 1000, g, lat, so, sa, sn, rd, e);
    total++; if (g !== 1'b1 || lat !== 2 || rd !== 32'h5555_5555 || e !== 1'b0)
      $display("FAIL midrst_next got gnt=%b cyc=%0d rdata=%h err=%b exp 1/2/55555555/0", g, lat, rd, e); else pass++;
  endtask
  initial begin
    test_reset;
    test_fixed_read;
    test_boundary;
    test_unmapped;
    test_read_only;
    test_handshake;
    test_overlap_busy;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
